// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads combinational imem, loads IF/ID one edge after the PC presents the address.
// Latency 1 cycle from imem_pc to if_id_*. Stall holds PC and IF/ID; a taken branch overrides stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_oob,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t       BUBBLE    = '0;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  logic [31:0] pc, pc_plus4, pc_nxt;
  ifid_t       ifid, ifid_nxt;
  logic        load_vld, oob_set;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_nxt   = pc;
    ifid_nxt = ifid;
    load_vld = 1'b0;
    oob_set  = 1'b0;
    if (branch_taken) begin
      pc_nxt   = branch_target & ~32'h3;
      ifid_nxt = BUBBLE;
    end else if (jump && !stall) begin
      pc_nxt   = jump_target & ~32'h3;
      ifid_nxt = BUBBLE;
    end else if (stall) begin
      if (flush) ifid_nxt = BUBBLE;
    end else begin
      pc_nxt = pc_plus4;
      if (flush) begin
        ifid_nxt = BUBBLE;
      end else if (pc > LAST_ADDR) begin
        // Address beyond the memory: never present garbage as a real instruction.
        ifid_nxt = BUBBLE;
        oob_set  = 1'b1;
      end else begin
        ifid_nxt = '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};
        load_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ifid        <= BUBBLE;
      fetch_oob   <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc   <= pc_nxt;
      ifid <= ifid_nxt;
      if (oob_set) fetch_oob <= 1'b1;
      if (load_vld && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
    end
  end

  assign imem_pc        = pc;
  assign if_id_instr    = ifid.instr;
  assign if_id_pc_plus4 = ifid.pc_plus4;
  assign if_id_valid    = ifid.valid;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage. Owns the program counter, drives the address into the byte-addressed, big-endian, combinational-read instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register.
- Applies stall, flush and redirect requests from the hazard unit, the ID stage (jump) and the EX stage (branch).
- Keeps a sticky out-of-range fault flag and a fetched-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_BYTES, 16384, instruction memory size in bytes; valid fetch addresses are 0..IMEM_BYTES-4

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
imem_pc  out  32  fetch address to instruction memory; equals PC register
imem_instr  in  32  instruction word returned combinationally for imem_pc
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  squash IF/ID contents (insert bubble)
branch_taken  in  1  EX-stage taken branch
branch_target  in  32  byte address for branch redirect
jump  in  1  ID-stage jump
jump_target  in  32  byte address for jump redirect
if_id_instr  out  32  captured instruction; 32'h0 (NOP) when bubble
if_id_pc_plus4  out  32  PC+4 of captured instruction
if_id_valid  out  1  IF/ID holds a real instruction
fetch_oob  out  1  sticky: a fetch was attempted at or above IMEM_BYTES
fetch_count  out  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst=1 at edge, overrides every other input):
  - pc=RESET_PC, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, fetch_oob=0, fetch_count=0.
  - Reset asserted mid-stall or mid-redirect discards the pending request.
- imem_pc is the PC register output directly; no combinational path from inputs to imem_pc.
- Instruction latency: the word at imem_pc in cycle N appears on if_id_instr after the edge ending cycle N.
- Per-edge priority: rst > branch_taken > jump > stall > normal.
- Normal cycle:
  - pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - IF/ID <= {imem_instr, pc+4, valid=1}.
- Branch redirect (branch_taken=1):
  - pc <= branch_target with bits [1:0] forced to 00.
  - IF/ID <= bubble (instr 0, pc_plus4 0, valid 0).
  - Taken even when stall=1, because the stalled ID instruction is wrong-path.
- Jump redirect (jump=1, branch_taken=0, stall=0):
  - pc <= jump_target with bits [1:0] forced to 00.
  - IF/ID <= bubble.
- Jump with stall=1 and no branch: ignored. The ID stage holds jump asserted until the stall clears.
- Stall (stall=1, no branch redirect): pc held. IF/ID held unless flush=1, in which case IF/ID <= bubble.
- Flush without stall or redirect: pc advances normally; IF/ID <= bubble.
- Out-of-range fetch: if pc > IMEM_BYTES-4 on an edge that would load IF/ID normally:
  - IF/ID <= bubble.
  - fetch_oob <= 1 and stays 1 until rst.
  - pc still advances or redirects per the rules above.
- fetch_count increments by 1 on each edge where IF/ID is loaded with valid=1. Saturates at 32'hFFFF_FFFF. Held during stalls and bubbles.
- Simultaneous flush and redirect: the redirect rule applies; the bubble result is identical.

Test Plan:
- Free run: imem preloaded with 0x49400000 @0, 0x49410004 @4, 0x49420008 @8; release rst → imem_pc 0,4,8,0xC on consecutive cycles; one cycle after pc=0, if_id_instr=0x49400000, pc_plus4=4, valid=1; fetch_count=3 after three edges.
- Stall: assert stall for 2 cycles while pc=8 → imem_pc stays 8; if_id_instr stays 0x49410004; fetch_count unchanged; release → if_id_instr=0x49420008 next edge.
- Branch over stall: branch_taken=1, target 0xA4, stall=1 → next cycle imem_pc=0xA4, if_id_valid=0, instr=0; following edge if_id_instr=0x24010001 @0xA4, pc_plus4=0xA8.
- Priority/alignment:
  - branch 0x9E and jump 0x08 in the same cycle → imem_pc=0x9C.
  - jump 0x08 alone with stall=1 → pc unchanged.
  - same jump with stall=0 → imem_pc=0x08.
- Out of range: RESET_PC=0x3FFC, IMEM_BYTES=16384 → first fetch valid, fetch_oob=0; next fetch at 0x4000 → valid=0, fetch_oob=1 and stays set through later fetches; rst clears it.
- Reset mid-operation: rst with stall=1, branch_taken=1, fetch_count=5 → next cycle imem_pc=RESET_PC, if_id_valid=0, fetch_count=0, fetch_oob=0.
